mem_store_buffer: RTL and testbench

- Store buffer between the pipeline MEM stage and the 32x32 data `Memory` block; it owns that block's `Din`/`Ewr`/`Dir` inputs and reads its `Mout` output.
- Queues up to DEPTH stores and drains them into `Memory` one word per cycle.
- Serves loads through the same memory port, with 1-cycle registered read latency.
- Loads see buffered stores either by forwarding or by stalling until the buffer is empty (see Optional Feature).

---
 rtl/mem_store_buffer.sv | 138 +++++++++++++
 tb/tb_mem_store_buffer.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_store_buffer.sv
// mem_store_buffer
//   Store buffer between the MEM stage and the 32x32 data Memory block. Stores
//   are queued in a DEPTH-entry circular FIFO and drained into Memory one word
//   per cycle. Loads use the same Memory port (priority over draining) and
//   return registered data one cycle after acceptance.
//
//   Build option: define STORE_FWD_EN to let loads be accepted at any time and
//   forward from the youngest matching buffered store. Without it, loads
//   stall until the buffer is empty and no store is arriving, and always read
//   Memory directly.
//
// Ports
//   clk, reset           rising-edge clock, synchronous active-high reset
//   st_valid/st_ready    store handshake, st_addr/st_data payload
//   ld_valid/ld_ready    load handshake, ld_addr payload
//   ld_rvalid/ld_rdata   load response, one cycle after acceptance
//   empty                no buffered stores
//   Din/Ewr/Dir          Memory write data, write enable, address
//   Mout                 Memory combinational read data for Dir

module mem_store_buffer #(
    parameter int DEPTH = 4,
    parameter int AW    = 5,
    parameter int DW    = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          st_valid,
    output logic          st_ready,
    input  logic [AW-1:0] st_addr,
    input  logic [DW-1:0] st_data,
    input  logic          ld_valid,
    output logic          ld_ready,
    input  logic [AW-1:0] ld_addr,
    output logic          ld_rvalid,
    output logic [DW-1:0] ld_rdata,
    output logic          empty,
    output logic [DW-1:0] Din,
    output logic          Ewr,
    output logic [AW-1:0] Dir,
    input  logic [DW-1:0] Mout
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } sb_entry_t;

    sb_entry_t     ent_q [DEPTH];
    logic [PW-1:0] head_q, tail_q;
    logic [CW-1:0] count_q;
    logic          ld_rvalid_q;
    logic [DW-1:0] ld_rdata_q;

    logic          push, pop, ld_acc;
    logic          fwd_hit;
    logic [DW-1:0] fwd_data;

    assign empty     = (count_q == '0);
    // Full means no store this cycle, even if a drain frees a slot at the edge.
    assign st_ready  = (count_q < CW'(DEPTH));
    assign push      = st_valid && st_ready;
    assign ld_acc    = ld_valid && ld_ready;
    // Loads own the Memory port when accepted; a reset cycle never writes.
    assign pop       = !reset && !ld_acc && !empty;

    assign ld_rvalid = ld_rvalid_q;
    assign ld_rdata  = ld_rdata_q;

`ifdef STORE_FWD_EN
    assign ld_ready = 1'b1;

    // Walk entries oldest to youngest so the last match is the youngest.
    // Only entries present at the start of the cycle are visible; a store
    // pushed in this same cycle is younger than the load.
    always_comb begin
        logic [PW-1:0] idx;
        fwd_hit  = 1'b0;
        fwd_data = '0;
        idx      = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head_q + PW'(i);
            if ((CW'(i) < count_q) && (ent_q[idx].addr == ld_addr)) begin
                fwd_hit  = 1'b1;
                fwd_data = ent_q[idx].data;
            end
        end
    end
`else
    // Without forwarding, a load may only proceed once Memory is up to date.
    assign ld_ready = empty && !st_valid;
    assign fwd_hit  = 1'b0;
    assign fwd_data = '0;
`endif

    // Memory port arbitration: accepted load, else drain head, else idle.
    always_comb begin
        Dir = '0;
        Din = '0;
        Ewr = 1'b0;
        if (ld_acc) begin
            Dir = ld_addr;
        end else if (pop) begin
            Dir = ent_q[head_q].addr;
            Din = ent_q[head_q].data;
            Ewr = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
            ld_rvalid_q <= 1'b0;
            ld_rdata_q  <= '0;
        end else begin
            if (push) tail_q <= tail_q + 1'b1;
            if (pop)  head_q <= head_q + 1'b1;
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
            ld_rvalid_q <= ld_acc;
            if (ld_acc) ld_rdata_q <= fwd_hit ? fwd_data : Mout;
        end
    end

    // Entry storage needs no reset: count_q gates every read of it.
    always_ff @(posedge clk) begin
        if (push && !reset) ent_q[tail_q] <= '{addr: st_addr, data: st_data};
    end

endmodule

// File: tb/tb_mem_store_buffer.sv
// Scoreboard bench for mem_store_buffer with a behavioural 32x32 Memory.
// Expected load data and expected Memory writes are queued when stimulus is
// issued; a negedge monitor pops and compares on ld_rvalid and Ewr.

module tb_mem_store_buffer;

    localparam int DEPTH = 4;
    localparam int AW    = 5;
    localparam int DW    = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          st_valid, st_ready;
    logic [AW-1:0] st_addr;
    logic [DW-1:0] st_data;
    logic          ld_valid, ld_ready;
    logic [AW-1:0] ld_addr;
    logic          ld_rvalid;
    logic [DW-1:0] ld_rdata;
    logic          empty;
    logic [DW-1:0] Din;
    logic          Ewr;
    logic [AW-1:0] Dir;
    logic [DW-1:0] Mout;

    mem_store_buffer #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .clk(clk), .reset(reset),
        .st_valid(st_valid), .st_ready(st_ready), .st_addr(st_addr), .st_data(st_data),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_addr(ld_addr),
        .ld_rvalid(ld_rvalid), .ld_rdata(ld_rdata), .empty(empty),
        .Din(Din), .Ewr(Ewr), .Dir(Dir), .Mout(Mout)
    );

    always #5 clk = ~clk;

    // Behavioural Memory: combinational read, write at the rising edge.
    logic [DW-1:0] mem [32] = '{default: '0};
    assign Mout = mem[Dir];
    always @(posedge clk) if (Ewr) mem[Dir] <= Din;

    int nvec = 0;
    int nerr = 0;
    logic [DW-1:0]    rq [$];
    logic [AW+DW-1:0] wq [$];
    logic [AW+DW-1:0] wexp;

    logic [AW-1:0] b_addr [4] = '{5'd1, 5'd15, 5'd31, 5'd15};
    logic [DW-1:0] b_data [4] = '{32'd1050, 32'd2100, 32'd3150, 32'd4200};
    logic [DW-1:0] exp31  [4] = '{32'd0, 32'd0, 32'd0, 32'd3150};

    bit sa_m, la_m, sdone, ldone;
    int n_m;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every response and every Memory write must be expected, in order.
    always @(negedge clk) begin
        if (ld_rvalid) begin
            if (rq.size() == 0) begin
                nvec++; nerr++;
                $display("FAIL unexpected_rvalid: got rdata %0d, expected no response", ld_rdata);
            end else begin
                chk("ld_rdata", ld_rdata, rq.pop_front());
            end
        end
        if (Ewr) begin
            if (wq.size() == 0) begin
                nvec++; nerr++;
                $display("FAIL unexpected_ewr: got write %0d:%0d, expected no write", Dir, Din);
            end else begin
                wexp = wq.pop_front();
                chk("wr_addr", 32'(Dir), 32'(wexp[AW+DW-1:DW]));
                chk("wr_data", Din, wexp[DW-1:0]);
            end
        end
    end

    // One cycle: sample handshakes at negedge, return just after the edge.
    task automatic tick(output bit sa, output bit la);
        @(negedge clk);
        sa = st_valid && st_ready;
        la = ld_valid && ld_ready;
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_store(input logic [AW-1:0] a, input logic [DW-1:0] d);
        bit sa, la;
        int n = 0;
        st_valid = 1'b1; st_addr = a; st_data = d;
        do begin tick(sa, la); n++; end while (!sa && n < 50);
        st_valid = 1'b0;
        chk("store_accept", 32'(sa), 1);
    endtask

    task automatic do_load(input logic [AW-1:0] a, input logic [DW-1:0] exp);
        bit sa, la;
        int n = 0;
        ld_valid = 1'b1; ld_addr = a;
        do begin tick(sa, la); n++; end while (!la && n < 50);
        ld_valid = 1'b0;
        chk("load_accept", 32'(la), 1);
        if (la) rq.push_back(exp);
    endtask

    task automatic wait_empty(input string name);
        int n = 0;
        @(negedge clk);
        while (!empty && n < 50) begin @(negedge clk); n++; end
        chk(name, 32'(empty), 1);
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        st_valid = 1'b0; st_addr = '0; st_data = '0;
        ld_valid = 1'b0; ld_addr = '0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // Reset state
        @(negedge clk);
        chk("rst_st_ready", 32'(st_ready), 1);
        chk("rst_empty", 32'(empty), 1);
        chk("rst_ld_rvalid", 32'(ld_rvalid), 0);
        chk("rst_ld_rdata", ld_rdata, 0);
        chk("rst_ewr", 32'(Ewr), 0);
        chk("rst_din", Din, 0);
        chk("rst_dir", 32'(Dir), 0);
        chk("rst_ld_ready", 32'(ld_ready), 1);
        @(posedge clk); #1;

        // Single store drains next cycle for one cycle, then a load reads it.
        wq.push_back({5'd1, 32'd1050});
        do_store(5'd1, 32'd1050);
        @(negedge clk);
        chk("single_ewr", 32'(Ewr), 1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("single_empty", 32'(empty), 1);
        @(posedge clk); #1;
        do_load(5'd1, 32'd1050);
        idle(2);
        @(negedge clk);
        chk("rdata_hold", ld_rdata, 1050);
        chk("rvalid_one_cycle", 32'(ld_rvalid), 0);
        @(posedge clk); #1;

        // Store and load to the same address in the same cycle, memory[15]=7.
        wq.push_back({5'd15, 32'd7});
        do_store(5'd15, 32'd7);
        wait_empty("preload_empty");
        wq.push_back({5'd15, 32'd2100});
        st_valid = 1'b1; st_addr = 5'd15; st_data = 32'd2100;
        ld_valid = 1'b1; ld_addr = 5'd15;
        sdone = 1'b0; ldone = 1'b0; n_m = 0;
        do begin
            tick(sa_m, la_m);
            n_m++;
            if (sa_m) begin sdone = 1'b1; st_valid = 1'b0; end
            if (la_m) begin
                ldone = 1'b1; ld_valid = 1'b0;
`ifdef STORE_FWD_EN
                rq.push_back(32'd7);     // store is younger: old memory value
`else
                rq.push_back(32'd2100);  // load waits for the drain
`endif
            end
        end while (!(sdone && ldone) && n_m < 50);
`ifdef STORE_FWD_EN
        chk("simul_cycles", 32'(n_m), 1);
`else
        chk("simul_cycles", 32'(n_m), 3);
`endif
        wait_empty("simul_empty");

        // Four back-to-back stores while a load at 31 is held.
        for (int k = 0; k < 4; k++) wq.push_back({b_addr[k], b_data[k]});
`ifdef STORE_FWD_EN
        wq.push_back({5'd7, 32'd77});
        ld_valid = 1'b1; ld_addr = 5'd31;
        for (int k = 0; k < 4; k++) begin
            st_valid = 1'b1; st_addr = b_addr[k]; st_data = b_data[k];
            tick(sa_m, la_m);
            chk("burst_st_acc", 32'(sa_m), 1);
            chk("burst_ld_acc", 32'(la_m), 1);
            if (la_m) rq.push_back(exp31[k]);
        end
        st_valid = 1'b0;
        @(negedge clk);
        chk("full_st_ready", 32'(st_ready), 0);
        chk("full_ewr_blocked", 32'(Ewr), 0);
        @(posedge clk); #1;
        rq.push_back(32'd3150);
        // Release the load and offer a store while full: drain happens, store waits.
        ld_valid = 1'b0;
        st_valid = 1'b1; st_addr = 5'd7; st_data = 32'd77;
        n_m = 0;
        do begin tick(sa_m, la_m); n_m++; end while (!sa_m && n_m < 10);
        st_valid = 1'b0;
        chk("full_wait_cycles", 32'(n_m), 2);
`else
        ld_valid = 1'b1; ld_addr = 5'd31;
        for (int k = 0; k < 4; k++) begin
            st_valid = 1'b1; st_addr = b_addr[k]; st_data = b_data[k];
            tick(sa_m, la_m);
            chk("burst_st_acc", 32'(sa_m), 1);
            chk("burst_ld_stall", 32'(la_m), 0);
        end
        st_valid = 1'b0;
        n_m = 0;
        do begin tick(sa_m, la_m); n_m++; end while (!la_m && n_m < 20);
        ld_valid = 1'b0;
        chk("ld_after_drain", 32'(la_m), 1);
        chk("ld_stall_cycles", 32'(n_m), 2);
        if (la_m) rq.push_back(32'd3150);
`endif
        wait_empty("burst_empty");
        do_load(5'd15, 32'd4200);

        // Ten stores: pointers wrap more than twice.
        for (int i = 0; i < 10; i++) begin
            wq.push_back({5'(16 + i), 32'(1000 + i)});
            do_store(5'(16 + i), 32'(1000 + i));
        end
        wait_empty("wrap_empty");
        do_load(5'd20, 32'd1004);
        do_load(5'd25, 32'd1009);
        idle(1);

        // Reset with entries buffered: they must never reach Memory.
`ifdef STORE_FWD_EN
        ld_valid = 1'b1; ld_addr = 5'd0;
        for (int k = 0; k < 3; k++) begin
            st_valid = 1'b1; st_addr = 5'(2 + k); st_data = 32'(500 + k);
            tick(sa_m, la_m);
            chk("pre_rst_st_acc", 32'(sa_m), 1);
            if (la_m) rq.push_back(32'd0);
        end
`else
        st_valid = 1'b1; st_addr = 5'd2; st_data = 32'd500;
        tick(sa_m, la_m);
        chk("pre_rst_st_acc", 32'(sa_m), 1);
`endif
        st_valid = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        chk("rst_mid_not_empty", 32'(empty), 0);
        chk("rst_mid_ewr", 32'(Ewr), 0);
        @(posedge clk); #1;
        reset = 1'b0;
        ld_valid = 1'b0;
        @(negedge clk);
        chk("post_rst_empty", 32'(empty), 1);
        chk("post_rst_rvalid", 32'(ld_rvalid), 0);
        chk("post_rst_rdata", ld_rdata, 0);
        chk("post_rst_st_ready", 32'(st_ready), 1);
        chk("post_rst_ewr", 32'(Ewr), 0);
        @(posedge clk); #1;
        idle(6);

        chk("rq_drained", 32'(rq.size()), 0);
        chk("wq_drained", 32'(wq.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
